// File: rtl/hram_irq_target_if.sv
// rtl/hram_irq_target_if.sv - CPU external bus bundle between the CPU (master) and a bus target (slave)
interface hram_irq_target_if;
  logic [15:0] a;
  logic [7:0]  din;
  logic        rd;
  logic        wr;
  logic [7:0]  dout;
  logic        hit;

  modport master (output a, output din, output rd, output wr, input dout, input hit);
  modport slave  (input a, input din, input rd, input wr, output dout, output hit);
endinterface

// File: rtl/hram_irq_target.sv
// rtl/hram_irq_target.sv - high RAM, IF and IE bus target with interrupt latching
// Optional UNMAPPED_FF_EN: unmapped reads return 8'hFF instead of 8'h00.
module hram_irq_target #(
  parameter logic [15:0] HRAM_BASE = 16'hFF80,
  parameter logic [15:0] IF_ADDR   = 16'hFF0F,
  parameter logic [15:0] IE_ADDR   = 16'hFFFF,
  parameter int          NUM_IRQ   = 5
) (
  input  logic               clk,
  input  logic               rst,
  hram_irq_target_if.slave   bus,
  input  logic [NUM_IRQ-1:0] int_req,
  input  logic [NUM_IRQ-1:0] int_ack,
  output logic [NUM_IRQ-1:0] int_pending
);

  localparam int HRAM_DEPTH = int'(IE_ADDR - HRAM_BASE);
  localparam int HRAM_AW    = $clog2(HRAM_DEPTH);

  logic [7:0]         hram [0:HRAM_DEPTH-1];
  logic [7:0]         ie_q;
  logic [NUM_IRQ-1:0] if_q;
  logic               wr_q;

  logic               sel_hram;
  logic               sel_if;
  logic               sel_ie;
  logic               wr_edge;
  logic [HRAM_AW-1:0] hram_idx;
  logic [7:0]         rdata;
  logic [NUM_IRQ-1:0] if_next;

  assign sel_hram = (bus.a >= HRAM_BASE) && (bus.a < IE_ADDR);
  assign sel_if   = (bus.a == IF_ADDR);
  assign sel_ie   = (bus.a == IE_ADDR);
  assign hram_idx = HRAM_AW'(bus.a - HRAM_BASE);
  assign wr_edge  = bus.wr & ~wr_q;

  // Request beats ack, and ack also clears a bit the CPU is writing this clock.
  assign if_next = (((wr_edge && sel_if) ? bus.din[NUM_IRQ-1:0] : if_q) & ~int_ack) | int_req;

  assign int_pending = ie_q[NUM_IRQ-1:0] & if_q;

  always_comb begin
`ifdef UNMAPPED_FF_EN
    rdata = 8'hFF;
`else
    rdata = 8'h00;
`endif
    if (sel_hram) begin
      rdata = hram[hram_idx];
    end else if (sel_if) begin
      rdata = 8'hFF;
      rdata[NUM_IRQ-1:0] = if_q;
    end else if (sel_ie) begin
      rdata = ie_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout <= 8'h00;
      bus.hit  <= 1'b0;
      ie_q     <= 8'h00;
      if_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      wr_q     <= bus.wr;
      if_q     <= if_next;
      bus.dout <= bus.rd ? rdata : 8'h00;
      bus.hit  <= bus.rd & (sel_hram | sel_if | sel_ie);
      if (wr_edge && sel_ie) begin
        ie_q <= bus.din;
      end
    end
  end

  // HRAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_edge && sel_hram) begin
      hram[hram_idx] <= bus.din;
    end
  end

endmodule

// File: tb/tb_hram_irq_target.sv
// tb/tb_hram_irq_target.sv - directed self-checking bench for hram_irq_target
module tb_hram_irq_target;
  logic       clk;
  logic       rst;
  logic [4:0] int_req;
  logic [4:0] int_ack;
  logic [4:0] int_pending;
  int         checks;
  int         errors;

  hram_irq_target_if bus ();

  hram_irq_target dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .int_req     (int_req),
    .int_ack     (int_ack),
    .int_pending (int_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] unmapped_exp;
`ifdef UNMAPPED_FF_EN
    unmapped_exp = 8'hFF;
`else
    unmapped_exp = 8'h00;
`endif
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.a = 16'h0000; bus.din = 8'h00; bus.rd = 1'b0; bus.wr = 1'b0;
    int_req = '0; int_ack = '0;
    step(); step();
    rst = 1'b0;
    check("reset_dout", {8'h00, bus.dout}, 16'h0000);
    check("reset_hit", {15'h0, bus.hit}, 16'h0000);
    check("reset_pending", {11'h0, int_pending}, 16'h0000);

    bus.rd = 1'b1; bus.a = 16'hFFFF; step();
    check("rd_ie_dout", {8'h00, bus.dout}, 16'h0000);
    check("rd_ie_hit", {15'h0, bus.hit}, 16'h0001);
    bus.a = 16'hFF0F; step();
    check("rd_if_dout", {8'h00, bus.dout}, 16'h00E0);
    bus.rd = 1'b0;

    bus.a = 16'hFF80; bus.din = 8'hA5; bus.wr = 1'b1; step();
    bus.wr = 1'b0; step();
    bus.a = 16'hFFFE; bus.din = 8'h3C; bus.wr = 1'b1; step();
    bus.wr = 1'b0; step();
    bus.rd = 1'b1; bus.a = 16'hFF80; step();
    check("rd_ff80", {8'h00, bus.dout}, 16'h00A5);
    bus.a = 16'hFFFE; step();
    check("rd_fffe", {8'h00, bus.dout}, 16'h003C);
    check("rd_fffe_hit", {15'h0, bus.hit}, 16'h0001);
    bus.rd = 1'b0; step();
    check("idle_dout", {8'h00, bus.dout}, 16'h0000);
    check("idle_hit", {15'h0, bus.hit}, 16'h0000);

    bus.a = 16'hFF90; bus.wr = 1'b1; bus.din = 8'h11; step();
    bus.din = 8'h22; step();
    bus.din = 8'h33; step();
    bus.wr = 1'b0; step();
    bus.rd = 1'b1; step();
    check("held_wr_once", {8'h00, bus.dout}, 16'h0011);
    bus.rd = 1'b0;

    bus.a = 16'hFFFF; bus.din = 8'h1F; bus.wr = 1'b1; step();
    bus.wr = 1'b0; step();
    check("pending_no_if", {11'h0, int_pending}, 16'h0000);
    int_req = 5'b00100; step();
    int_req = '0;
    check("pending_req", {11'h0, int_pending}, 16'h0004);
    bus.rd = 1'b1; bus.a = 16'hFF0F; step();
    check("rd_if_set", {8'h00, bus.dout}, 16'h00E4);
    bus.rd = 1'b0;
    int_ack = 5'b00100; int_req = 5'b00100; step();
    int_ack = '0; int_req = '0;
    check("req_beats_ack", {11'h0, int_pending}, 16'h0004);
    int_ack = 5'b00100; step();
    int_ack = '0;
    check("ack_clears", {11'h0, int_pending}, 16'h0000);

    int_req = 5'b01000; step();
    int_req = '0;
    check("pending_b3", {11'h0, int_pending}, 16'h0008);
    bus.a = 16'hFF0F; bus.din = 8'h00; bus.wr = 1'b1; int_req = 5'b00001; step();
    bus.wr = 1'b0; int_req = '0;
    check("req_beats_wr", {11'h0, int_pending}, 16'h0001);
    step();
    bus.din = 8'h02; bus.wr = 1'b1; int_ack = 5'b00010; step();
    bus.wr = 1'b0; int_ack = '0;
    check("ack_beats_wr", {11'h0, int_pending}, 16'h0000);
    step();

    bus.a = 16'hFF80; bus.din = 8'h5A; bus.rd = 1'b1; bus.wr = 1'b1; step();
    check("rdwr_old", {8'h00, bus.dout}, 16'h00A5);
    bus.wr = 1'b0; step();
    check("rd_after_wr", {8'h00, bus.dout}, 16'h005A);

    bus.a = 16'hC000; step();
    check("unmapped_hit", {15'h0, bus.hit}, 16'h0000);
    check("unmapped_dout", {8'h00, bus.dout}, {8'h00, unmapped_exp});
    rst = 1'b1; step();
    check("rst_mid_dout", {8'h00, bus.dout}, 16'h0000);
    check("rst_mid_hit", {15'h0, bus.hit}, 16'h0000);
    rst = 1'b0; bus.rd = 1'b0;

    bus.a = 16'hFFA0; bus.din = 8'h66; bus.wr = 1'b1; rst = 1'b1; step();
    rst = 1'b0; bus.din = 8'h77; step();
    bus.din = 8'h88; step();
    bus.wr = 1'b0; step();
    check("post_rst_pending", {11'h0, int_pending}, 16'h0000);
    bus.rd = 1'b1; step();
    check("rst_wr_commit", {8'h00, bus.dout}, 16'h0077);
    bus.a = 16'hFF90; step();
    check("hram_kept", {8'h00, bus.dout}, 16'h0011);
    bus.a = 16'hFFFF; step();
    check("ie_reset", {8'h00, bus.dout}, 16'h0000);
    bus.rd = 1'b0; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hram_irq_target.md
Name: hram_irq_target

Overview:
- Bus responder (target) for the CPU external bus: decodes `a`/`rd`/`wr` from the CPU and returns read data on `dout` toward the CPU `din`.
- Owns high RAM (FF80–FFFE), interrupt flag register IF (FF0F) and interrupt enable register IE (FFFF).
- Latches peripheral interrupt requests into IF and presents enabled pending interrupts to the CPU interrupt logic.
- Sits beside the other bus targets; the top-level read mux selects `dout` when `hit` is asserted.

Parameters:
- HRAM_BASE, 16'hFF80, first HRAM address; HRAM spans HRAM_BASE .. IE_ADDR-1.
- IF_ADDR, 16'hFF0F, address of the interrupt flag register.
- IE_ADDR, 16'hFFFF, address of the interrupt enable register.
- NUM_IRQ, 5, number of interrupt sources (IF/IE bits [NUM_IRQ-1:0]).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- a  input  16  CPU address bus.
- din  input  8  write data from the CPU (CPU `dout`).
- rd  input  1  CPU read strobe.
- wr  input  1  CPU write strobe.
- dout  output  8  registered read data to the CPU (CPU `din`).
- hit  output  1  registered; this block claimed the current read.
- int_req  input  NUM_IRQ  one-clock request pulses from peripherals.
- int_ack  input  NUM_IRQ  one-clock clear pulses from CPU interrupt entry.
- int_pending  output  NUM_IRQ  IE[NUM_IRQ-1:0] & IF, combinational from registers.

Behaviour:
- Reset: one clock, synchronous and active-high.
  - Sets dout=8'h00, hit=0, IE=8'h00, IF=0, wr_q=0.
  - HRAM contents are not cleared (undefined after power-up, preserved across rst).
- Decode:
  - sel_hram when HRAM_BASE <= a < IE_ADDR.
  - sel_if when a == IF_ADDR.
  - sel_ie when a == IE_ADDR.
  - mapped = any of the three.
- Read path, 1-clock latency:
  - Every clock with rd=1: dout <= read data of the current `a`; hit <= mapped.
  - With rd=0: dout <= 8'h00 and hit <= 0.
  - The CPU asserts rd for two clocks before sampling, so data is valid at its sample edge.
- Read data:
  - HRAM: the byte at a-HRAM_BASE.
  - IF: bits [7:NUM_IRQ] read as 1, low bits read as IF.
  - IE: full 8 bits as stored.
  - Unmapped: see Optional Feature.
- Write path:
  - The write commits exactly once, on the clock where wr=1 and wr_q=0 (rising-edge detect); wr_q <= wr every clock.
  - wr held high for several clocks performs no further writes.
  - HRAM write: byte at a-HRAM_BASE <= din.
  - IE write: IE <= din.
  - IF write: takes din[NUM_IRQ-1:0].
  - Unmapped writes are ignored.
- IF update, every clock: IF <= ((if_wr ? din[NUM_IRQ-1:0] : IF) & ~int_ack) | int_req.
  - int_req wins over int_ack and over a CPU write clearing the same bit, in the same clock.
  - int_ack clears a bit set only by the CPU write in that clock.
- rd and wr both high in one clock:
  - The write commits.
  - dout captures the pre-write value of the addressed location.
- Read of a location written in the previous clock returns the new value.
- int_pending reflects IE/IF updates one clock after the causing edge; no extra latency.
- Reset mid-transaction: any pending write edge is discarded. After rst deasserts, wr_q=0, so a wr still held high commits once on the next clock.

Optional Feature:
- Macro: UNMAPPED_FF_EN.
- Defined: a read of an unmapped address drives dout=8'hFF (open-bus emulation); hit still 0.
- Undefined: an unmapped read drives dout=8'h00.
- Mapped behaviour is identical in both builds.

Test Plan:
- Reset, then read FFFF and FF0F → dout=8'h00 and 8'hE0 respectively; hit=1 one clock after rd rises; int_pending=0.
- Write 8'hA5 to FF80 and 8'h3C to FFFE (wr pulse 1 clock), then read both → dout=8'hA5 and 8'h3C, each one clock after rd.
- Hold wr high 3 clocks at FF90 with din changing 8'h11→8'h22→8'h33 → FF90 reads 8'h11 (single commit).
- Write IE=8'h1F; pulse int_req=5'b00100 → IF=5'b00100, int_pending=5'b00100 next clock. Then drive int_ack=5'b00100 and int_req=5'b00100 in the same clock → bit stays set. Then int_ack alone → cleared.
- CPU writes IF=8'h00 in the same clock int_req=5'b00001 → IF=5'b00001.
- Read 16'hC000 → hit=0; dout=8'hFF with UNMAPPED_FF_EN, 8'h00 without. Assert rst mid-read → dout=0, hit=0 next clock.
